// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer for the shared execute-stage comparator.
// Latches one branch, decodes the result, redirects and flushes on mispredict.
module branch_resolve_ctrl #(
  parameter int REG_WIDTH    = 32,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_funct3,
  input  logic [REG_WIDTH-1:0] req_rs1,
  input  logic [REG_WIDTH-1:0] req_rs2,
  input  logic [PC_WIDTH-1:0]  req_pc,
  input  logic [PC_WIDTH-1:0]  req_target,
  input  logic                 req_pred_taken,
  input  logic                 kill,
  output logic                 cmp_br_un,
  output logic [REG_WIDTH-1:0] cmp_rs1,
  output logic [REG_WIDTH-1:0] cmp_rs2,
  input  logic                 cmp_br_eq,
  input  logic                 cmp_br_lt,
  output logic                 resolve_valid,
  output logic                 resolve_taken,
  output logic                 illegal_br,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CMP     = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] FLUSH   = 2'd3;

  localparam logic [31:0] FCNT_INIT =
    32'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic [2:0]           f3_q;
  logic [REG_WIDTH-1:0] rs1_q;
  logic [REG_WIDTH-1:0] rs2_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [PC_WIDTH-1:0]  tgt_q;
  logic [PC_WIDTH-1:0]  rpc_q;
  logic [PC_WIDTH-1:0]  nxt_pc;
  logic                 pred_q;
  logic                 eq_q;
  logic                 lt_q;
  logic [31:0]          fcnt;
  logic                 taken;
  logic                 illegal;
  logic                 res;
  logic                 mis;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      f3_q == 3'b000:        taken = eq_q;
      f3_q == 3'b001:        taken = !eq_q;
      f3_q[2] && !f3_q[0]:   taken = lt_q;
      f3_q[2] && f3_q[0]:    taken = !lt_q;
      default:               illegal = 1'b1;
    endcase
  end

  // Kill in RESOLVE wins over every pulse this cycle.
  assign res    = (state == RESOLVE) && !kill;
  assign mis    = res && (taken != pred_q);
  assign nxt_pc = taken ? tgt_q : pc_q + PC_WIDTH'(4);

  assign req_ready      = (state == IDLE);
  assign resolve_valid  = res;
  assign resolve_taken  = res && taken;
  assign illegal_br     = res && illegal;
  assign redirect_valid = mis;
  assign redirect_pc    = mis ? nxt_pc : rpc_q;
  assign flush          = mis || (state == FLUSH);

  assign cmp_rs1   = rs1_q;
  assign cmp_rs2   = rs2_q;
  assign cmp_br_un = f3_q[1];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = CMP;
      CMP:     state_nx = kill ? IDLE : RESOLVE;
      RESOLVE: state_nx = (mis && FLUSH_CYCLES > 1) ? FLUSH : IDLE;
      FLUSH:   if (fcnt == 32'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      f3_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      pc_q           <= '0;
      tgt_q          <= '0;
      pred_q         <= 1'b0;
      eq_q           <= 1'b0;
      lt_q           <= 1'b0;
      rpc_q          <= '0;
      fcnt           <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        f3_q   <= req_funct3;
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        pc_q   <= req_pc;
        tgt_q  <= req_target;
        pred_q <= req_pred_taken;
      end
      if (state == CMP) begin
        eq_q <= cmp_br_eq;
        lt_q <= cmp_br_lt;
      end
      if (mis) begin
        rpc_q <= nxt_pc;
        fcnt  <= FCNT_INIT;
      end else if (state == FLUSH && fcnt != 32'd0) begin
        fcnt <= fcnt - 32'd1;
      end
      if (res && branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (mis && mispredict_cnt != '1)
        mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: main instance with defaults,
// second instance with 2-bit counters for saturation and back-to-back issue.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [31:0] req_pc = '0;
  logic [31:0] req_target = '0;
  logic        req_pred_taken = 1'b0;
  logic        kill = 1'b0;
  logic        cmp_br_un;
  logic [31:0] cmp_rs1;
  logic [31:0] cmp_rs2;
  logic        cmp_br_eq;
  logic        cmp_br_lt;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        illegal_br;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_kill = 1'b0;
  logic        s_br_un;
  logic [31:0] s_rs1;
  logic [31:0] s_rs2;
  logic        s_eq;
  logic        s_lt;
  logic        s_rv;
  logic        s_rt;
  logic        s_ill;
  logic        s_redv;
  logic [31:0] s_redpc;
  logic        s_flush;
  logic [1:0]  s_bcnt;
  logic [1:0]  s_mcnt;

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  assign cmp_br_eq = (cmp_rs1 == cmp_rs2);
  assign cmp_br_lt = cmp_br_un ? (cmp_rs1 < cmp_rs2)
                               : ($signed(cmp_rs1) < $signed(cmp_rs2));
  assign s_eq = (s_rs1 == s_rs2);
  assign s_lt = s_br_un ? (s_rs1 < s_rs2) : ($signed(s_rs1) < $signed(s_rs2));

  branch_resolve_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_pc(req_pc), .req_target(req_target),
    .req_pred_taken(req_pred_taken), .kill(kill),
    .cmp_br_un(cmp_br_un), .cmp_rs1(cmp_rs1), .cmp_rs2(cmp_rs2),
    .cmp_br_eq(cmp_br_eq), .cmp_br_lt(cmp_br_lt),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .illegal_br(illegal_br), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_resolve_ctrl #(.CNT_WIDTH(2)) sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_valid), .req_ready(s_ready),
    .req_funct3(3'b001), .req_rs1(32'd7), .req_rs2(32'd7),
    .req_pc(32'h500), .req_target(32'h600),
    .req_pred_taken(1'b1), .kill(s_kill),
    .cmp_br_un(s_br_un), .cmp_rs1(s_rs1), .cmp_rs2(s_rs2),
    .cmp_br_eq(s_eq), .cmp_br_lt(s_lt),
    .resolve_valid(s_rv), .resolve_taken(s_rt),
    .illegal_br(s_ill), .redirect_valid(s_redv),
    .redirect_pc(s_redpc), .flush(s_flush),
    .branch_cnt(s_bcnt), .mispredict_cnt(s_mcnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pred);
    req_funct3 = f3;
    req_rs1 = a;
    req_rs2 = b;
    req_pc = pc;
    req_target = tgt;
    req_pred_taken = pred;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    ncmp++; if (req_ready !== 1'b1) begin nbad++; $display("FAIL rst_ready got %b want 1", req_ready); end
    ncmp++; if (flush !== 1'b0) begin nbad++; $display("FAIL rst_flush got %b want 0", flush); end
    ncmp++; if (resolve_valid !== 1'b0) begin nbad++; $display("FAIL rst_rv got %b want 0", resolve_valid); end
    ncmp++; if (redirect_pc !== 32'h0) begin nbad++; $display("FAIL rst_rpc got %h want 0", redirect_pc); end
    ncmp++; if (cmp_rs1 !== 32'h0) begin nbad++; $display("FAIL rst_rs1 got %h want 0", cmp_rs1); end
    ncmp++; if (branch_cnt !== 16'h0) begin nbad++; $display("FAIL rst_bcnt got %0d want 0", branch_cnt); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_beq_mispredict();
    issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0);
    ncmp++; if (req_ready !== 1'b0) begin nbad++; $display("FAIL beq_cmp_ready got %b want 0", req_ready); end
    ncmp++; if (cmp_rs1 !== 32'd5) begin nbad++; $display("FAIL beq_cmp_rs1 got %h want 5", cmp_rs1); end
    step();
    ncmp++; if (resolve_valid !== 1'b1) begin nbad++; $display("FAIL beq_rv got %b want 1", resolve_valid); end
    ncmp++; if (resolve_taken !== 1'b1) begin nbad++; $display("FAIL beq_taken got %b want 1", resolve_taken); end
    ncmp++; if (redirect_valid !== 1'b1) begin nbad++; $display("FAIL beq_redv got %b want 1", redirect_valid); end
    ncmp++; if (redirect_pc !== 32'h140) begin nbad++; $display("FAIL beq_rpc got %h want 140", redirect_pc); end
    ncmp++; if (flush !== 1'b1) begin nbad++; $display("FAIL beq_flush1 got %b want 1", flush); end
    step();
    ncmp++; if (flush !== 1'b1) begin nbad++; $display("FAIL beq_flush2 got %b want 1", flush); end
    ncmp++; if (req_ready !== 1'b0) begin nbad++; $display("FAIL beq_t3_ready got %b want 0", req_ready); end
    ncmp++; if (redirect_valid !== 1'b0) begin nbad++; $display("FAIL beq_redv_t3 got %b want 0", redirect_valid); end
    ncmp++; if (redirect_pc !== 32'h140) begin nbad++; $display("FAIL beq_rpc_hold got %h want 140", redirect_pc); end
    ncmp++; if (mispredict_cnt !== 16'd1) begin nbad++; $display("FAIL beq_mcnt got %0d want 1", mispredict_cnt); end
    step();
    ncmp++; if (flush !== 1'b0) begin nbad++; $display("FAIL beq_flush_end got %b want 0", flush); end
    ncmp++; if (req_ready !== 1'b1) begin nbad++; $display("FAIL beq_t4_ready got %b want 1", req_ready); end
  endtask

  task automatic test_blt_bltu();
    issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b1);
    ncmp++; if (cmp_br_un !== 1'b0) begin nbad++; $display("FAIL blt_un got %b want 0", cmp_br_un); end
    step();
    ncmp++; if (resolve_taken !== 1'b1) begin nbad++; $display("FAIL blt_taken got %b want 1", resolve_taken); end
    ncmp++; if (redirect_valid !== 1'b0) begin nbad++; $display("FAIL blt_redv got %b want 0", redirect_valid); end
    ncmp++; if (flush !== 1'b0) begin nbad++; $display("FAIL blt_flush got %b want 0", flush); end
    step();
    ncmp++; if (req_ready !== 1'b1) begin nbad++; $display("FAIL blt_t3_ready got %b want 1", req_ready); end
    ncmp++; if (branch_cnt !== 16'd2) begin nbad++; $display("FAIL blt_bcnt got %0d want 2", branch_cnt); end
    issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1'b1);
    ncmp++; if (cmp_br_un !== 1'b1) begin nbad++; $display("FAIL bltu_un got %b want 1", cmp_br_un); end
    step();
    ncmp++; if (resolve_taken !== 1'b0) begin nbad++; $display("FAIL bltu_taken got %b want 0", resolve_taken); end
    ncmp++; if (redirect_valid !== 1'b1) begin nbad++; $display("FAIL bltu_redv got %b want 1", redirect_valid); end
    ncmp++; if (redirect_pc !== 32'h204) begin nbad++; $display("FAIL bltu_rpc got %h want 204", redirect_pc); end
    step();
    step();
    ncmp++; if (mispredict_cnt !== 16'd2) begin nbad++; $display("FAIL bltu_mcnt got %0d want 2", mispredict_cnt); end
  endtask

  task automatic test_pc_wrap();
    issue(3'b101, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h40, 1'b1);
    step();
    ncmp++; if (resolve_taken !== 1'b0) begin nbad++; $display("FAIL wrap_taken got %b want 0", resolve_taken); end
    ncmp++; if (redirect_pc !== 32'h0) begin nbad++; $display("FAIL wrap_rpc got %h want 0", redirect_pc); end
    step();
    step();
    ncmp++; if (branch_cnt !== 16'd4) begin nbad++; $display("FAIL wrap_bcnt got %0d want 4", branch_cnt); end
  endtask

  task automatic test_kill();
    issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0);
    kill = 1'b1;
    step();
    kill = 1'b0;
    ncmp++; if (resolve_valid !== 1'b0) begin nbad++; $display("FAIL killc_rv got %b want 0", resolve_valid); end
    ncmp++; if (req_ready !== 1'b1) begin nbad++; $display("FAIL killc_ready got %b want 1", req_ready); end
    issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0);
    step();
    kill = 1'b1;
    #1;
    ncmp++; if (resolve_valid !== 1'b0) begin nbad++; $display("FAIL killr_rv got %b want 0", resolve_valid); end
    ncmp++; if (redirect_valid !== 1'b0) begin nbad++; $display("FAIL killr_redv got %b want 0", redirect_valid); end
    ncmp++; if (flush !== 1'b0) begin nbad++; $display("FAIL killr_flush got %b want 0", flush); end
    step();
    kill = 1'b0;
    ncmp++; if (req_ready !== 1'b1) begin nbad++; $display("FAIL killr_ready got %b want 1", req_ready); end
    ncmp++; if (branch_cnt !== 16'd4) begin nbad++; $display("FAIL kill_bcnt got %0d want 4", branch_cnt); end
    ncmp++; if (mispredict_cnt !== 16'd3) begin nbad++; $display("FAIL kill_mcnt got %0d want 3", mispredict_cnt); end
  endtask

  task automatic test_illegal();
    issue(3'b010, 32'd3, 32'd3, 32'h400, 32'h480, 1'b0);
    step();
    ncmp++; if (resolve_valid !== 1'b1) begin nbad++; $display("FAIL ill_rv got %b want 1", resolve_valid); end
    ncmp++; if (illegal_br !== 1'b1) begin nbad++; $display("FAIL ill_flag got %b want 1", illegal_br); end
    ncmp++; if (resolve_taken !== 1'b0) begin nbad++; $display("FAIL ill_taken got %b want 0", resolve_taken); end
    ncmp++; if (redirect_valid !== 1'b0) begin nbad++; $display("FAIL ill_redv got %b want 0", redirect_valid); end
    step();
    ncmp++; if (illegal_br !== 1'b0) begin nbad++; $display("FAIL ill_pulse got %b want 0", illegal_br); end
  endtask

  task automatic test_back_to_back();
    int rv_seen = 0;
    int rdy_seen = 0;
    logic prev_rdy;
    s_valid = 1'b1;
    prev_rdy = s_ready;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (s_rv) rv_seen++;
      if (k <= 17 && s_ready) rdy_seen++;
      if (k <= 17 && prev_rdy && s_ready) begin
        ncmp++; nbad++;
        $display("FAIL b2b_accept cycle %0d got ready twice want accept", k);
      end
      prev_rdy = s_ready;
      if (k == 17) s_valid = 1'b0;
    end
    ncmp++; if (rv_seen != 5) begin nbad++; $display("FAIL b2b_resolves got %0d want 5", rv_seen); end
    ncmp++; if (rdy_seen != 4) begin nbad++; $display("FAIL b2b_ready_cycles got %0d want 4", rdy_seen); end
    ncmp++; if (s_mcnt !== 2'd3) begin nbad++; $display("FAIL sat_mcnt got %0d want 3", s_mcnt); end
    ncmp++; if (s_bcnt !== 2'd3) begin nbad++; $display("FAIL sat_bcnt got %0d want 3", s_bcnt); end
    ncmp++; if (s_ready !== 1'b1) begin nbad++; $display("FAIL b2b_idle got %b want 1", s_ready); end
  endtask

  task automatic test_reset_mid_flush();
    issue(3'b000, 32'd9, 32'd9, 32'h700, 32'h780, 1'b0);
    step();
    step();
    ncmp++; if (flush !== 1'b1) begin nbad++; $display("FAIL rmf_pre_flush got %b want 1", flush); end
    #2;
    rst_n = 1'b0;
    #1;
    ncmp++; if (flush !== 1'b0) begin nbad++; $display("FAIL rmf_flush got %b want 0", flush); end
    ncmp++; if (req_ready !== 1'b1) begin nbad++; $display("FAIL rmf_ready got %b want 1", req_ready); end
    ncmp++; if (branch_cnt !== 16'd0) begin nbad++; $display("FAIL rmf_bcnt got %0d want 0", branch_cnt); end
    ncmp++; if (mispredict_cnt !== 16'd0) begin nbad++; $display("FAIL rmf_mcnt got %0d want 0", mispredict_cnt); end
    ncmp++; if (redirect_pc !== 32'h0) begin nbad++; $display("FAIL rmf_rpc got %h want 0", redirect_pc); end
    step();
    rst_n = 1'b1;
    step();
    ncmp++; if (flush !== 1'b0) begin nbad++; $display("FAIL rmf_post_flush got %b want 0", flush); end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_blt_bltu();
    test_pc_wrap();
    test_kill();
    test_illegal();
    test_back_to_back();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
